ghash_accumulator: RTL and testbench

- Sequencing stage directly upstream of the GF(2^128) multiplier in the GCM datapath. Accepts AAD and ciphertext blocks over a valid/ready stream.
- For each block, drives the multiplier with H and (Y xor block), then registers the product as the new running hash Y.
- After the final data block it hashes the length block {len(A), len(C)} and presents the GHASH result to the tag stage.

---
 rtl/ghash_accumulator.sv | 161 ++++++++++++++++
 tb/tb_ghash_accumulator.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_accumulator.sv
// GHASH sequencing stage: folds AAD/ciphertext blocks and the length block through an external GF(2^128) multiplier.
// Optional block-order checking (AAD after ciphertext) is enabled with `define GHASH_ORDER_CHK_EN.
module ghash_accumulator #(
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] h_i,
    input  logic                  blk_valid_i,
    output logic                  blk_ready_o,
    input  logic [DATA_WIDTH-1:0] blk_data_i,
    input  logic                  blk_type_i,
    input  logic [4:0]            blk_bytes_i,
    input  logic                  fin_i,
    output logic [DATA_WIDTH-1:0] mul_h_o,
    output logic [DATA_WIDTH-1:0] mul_a_o,
    input  logic [DATA_WIDTH-1:0] mul_x_i,
    output logic                  tag_valid_o,
    input  logic                  tag_ready_i,
    output logic [DATA_WIDTH-1:0] tag_o,
    output logic                  busy_o
`ifdef GHASH_ORDER_CHK_EN
    ,
    output logic                  order_err_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_LEN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] h_q, h_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic [DATA_WIDTH-1:0] tag_q, tag_d;
    logic [LEN_WIDTH-1:0]  aad_len_q, aad_len_d;
    logic [LEN_WIDTH-1:0]  ct_len_q, ct_len_d;

    logic [4:0]            nbytes;
    logic [DATA_WIDTH-1:0] byte_mask;
    logic [LEN_WIDTH-1:0]  blk_bits;
    logic                  blk_acc;

    assign blk_acc  = (state_q == S_ACCUM) && blk_valid_i;
    assign nbytes   = ((blk_bytes_i == 5'd0) || (blk_bytes_i > 5'd16)) ? 5'd16 : blk_bytes_i;
    assign blk_bits = {{(LEN_WIDTH-8){1'b0}}, nbytes, 3'b000};

    // Byte 0 sits in the top byte lane, so lanes at index >= nbytes are cleared from the MSB end down.
    always_comb begin
        byte_mask = '0;
        for (int k = 0; k < DATA_WIDTH/8; k++) begin
            byte_mask[DATA_WIDTH-1-8*k -: 8] = (5'(k) < nbytes) ? 8'hFF : 8'h00;
        end
    end

    always_comb begin
        mul_a_o = y_q;
        if (blk_acc)
            mul_a_o = y_q ^ (blk_data_i & byte_mask);
        else if (state_q == S_LEN)
            mul_a_o = y_q ^ {aad_len_q, ct_len_q};
    end

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        y_d       = y_q;
        tag_d     = tag_q;
        aad_len_d = aad_len_q;
        ct_len_d  = ct_len_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    h_d       = h_i;
                    y_d       = '0;
                    aad_len_d = '0;
                    ct_len_d  = '0;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (blk_valid_i) begin
                    y_d = mul_x_i;
                    if (blk_type_i)
                        ct_len_d = ct_len_q + blk_bits;
                    else
                        aad_len_d = aad_len_q + blk_bits;
                end
                if (fin_i)
                    state_d = S_LEN;
            end
            S_LEN: begin
                tag_d   = mul_x_i;
                state_d = S_DONE;
            end
            default: begin
                if (tag_ready_i)
                    state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            h_q       <= '0;
            y_q       <= '0;
            tag_q     <= '0;
            aad_len_q <= '0;
            ct_len_q  <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            y_q       <= y_d;
            tag_q     <= tag_d;
            aad_len_q <= aad_len_d;
            ct_len_q  <= ct_len_d;
        end
    end

`ifdef GHASH_ORDER_CHK_EN
    logic seen_ct_q, seen_ct_d;
    logic order_err_q, order_err_d;

    always_comb begin
        seen_ct_d   = seen_ct_q;
        order_err_d = order_err_q;
        if ((state_q == S_IDLE) && start_i) begin
            seen_ct_d   = 1'b0;
            order_err_d = 1'b0;
        end else if (blk_acc) begin
            if (blk_type_i)
                seen_ct_d = 1'b1;
            else if (seen_ct_q)
                order_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_ct_q   <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            seen_ct_q   <= seen_ct_d;
            order_err_q <= order_err_d;
        end
    end

    assign order_err_o = order_err_q;
`endif

    assign mul_h_o     = h_q;
    assign tag_o       = tag_q;
    assign blk_ready_o = (state_q == S_ACCUM);
    assign tag_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ghash_accumulator.sv
// Randomized bench for ghash_accumulator: supplies the GF(2^128) multiplier and tracks expected
// outputs with a message-level GHASH model; order-error checks are compiled in with GHASH_ORDER_CHK_EN.
module tb_ghash_accumulator;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [127:0] h_i;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic [127:0] blk_data_i;
    logic         blk_type_i;
    logic [4:0]   blk_bytes_i;
    logic         fin_i;
    logic [127:0] mul_h_o;
    logic [127:0] mul_a_o;
    logic [127:0] mul_x_i;
    logic         tag_valid_o;
    logic         tag_ready_i;
    logic [127:0] tag_o;
    logic         busy_o;
`ifdef GHASH_ORDER_CHK_EN
    logic         order_err_o;
`endif

    ghash_accumulator #(.DATA_WIDTH(128), .LEN_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .h_i(h_i),
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
        .blk_type_i(blk_type_i), .blk_bytes_i(blk_bytes_i), .fin_i(fin_i),
        .mul_h_o(mul_h_o), .mul_a_o(mul_a_o), .mul_x_i(mul_x_i),
        .tag_valid_o(tag_valid_o), .tag_ready_i(tag_ready_i), .tag_o(tag_o), .busy_o(busy_o)
`ifdef GHASH_ORDER_CHK_EN
        , .order_err_o(order_err_o)
`endif
    );

    always #5 clk = ~clk;

    // GCM bit-reflected multiply in GF(2^128), x^128 + x^7 + x^2 + x + 1.
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z = '0;
        logic [127:0] v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'he1, 120'd0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    assign mul_x_i = gf_mul(mul_a_o, mul_h_o);

    typedef struct {
        logic [127:0] d;
        logic         t;
        logic [4:0]   n;
    } blk_t;
    blk_t msg_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Model of what the outputs must be: phase 0 idle, 1 accumulate, 2 length, 3 done.
    int           phase;
    logic [127:0] m_h, m_y, m_tag, exp_a;
    logic [63:0]  m_alen, m_clen;
    logic         m_oerr, m_seen_ct;
    logic         chk_en = 1'b0;
    logic         chk_a  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int norm(input logic [4:0] n);
        return (n == 5'd0 || n > 5'd16) ? 16 : int'(n);
    endfunction

    function automatic logic [127:0] pad_blk(input logic [127:0] d, input logic [4:0] n);
        logic [127:0] r = '0;
        for (int k = 0; k < norm(n); k++) r[127-8*k -: 8] = d[127-8*k -: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("blk_ready", 128'(blk_ready_o), 128'(phase == 1));
            chk("busy", 128'(busy_o), 128'(phase != 0));
            chk("tag_valid", 128'(tag_valid_o), 128'(phase == 3));
            chk("tag_o", tag_o, m_tag);
            chk("mul_h", mul_h_o, m_h);
            if (chk_a) chk("mul_a", mul_a_o, exp_a);
`ifdef GHASH_ORDER_CHK_EN
            chk("order_err", 128'(order_err_o), 128'(m_oerr));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_i     = 1'b0;
        h_i         = rnd128();
        blk_valid_i = 1'b0;
        blk_data_i  = rnd128();
        blk_type_i  = 1'($urandom_range(0, 1));
        blk_bytes_i = 5'($urandom_range(0, 31));
        fin_i       = 1'b0;
        tag_ready_i = 1'b0;
    endtask

    task automatic model_zero();
        phase = 0; m_h = '0; m_y = '0; m_tag = '0; m_alen = '0; m_clen = '0;
        m_oerr = 1'b0; m_seen_ct = 1'b0; exp_a = '0;
    endtask

    task automatic start_msg(input logic [127:0] h);
        idle_inputs();
        start_i = 1'b1;
        h_i     = h;
        chk_a   = 1'b0;
        tick();
        phase = 1; m_h = h; m_y = '0; m_alen = '0; m_clen = '0;
        m_oerr = 1'b0; m_seen_ct = 1'b0;
    endtask

    task automatic send_block(input int i, input bit fin, input int max_gap);
        repeat ($urandom_range(0, max_gap)) begin
            idle_inputs();
            start_i = 1'($urandom_range(0, 1));
            exp_a   = m_y;
            chk_a   = 1'b1;
            tick();
        end
        idle_inputs();
        blk_valid_i = 1'b1;
        blk_data_i  = msg_q[i].d;
        blk_type_i  = msg_q[i].t;
        blk_bytes_i = msg_q[i].n;
        fin_i       = fin;
        start_i     = 1'($urandom_range(0, 1));
        exp_a       = m_y ^ pad_blk(msg_q[i].d, msg_q[i].n);
        chk_a       = 1'b1;
        tick();
        m_y = gf_mul(exp_a, m_h);
        if (msg_q[i].t) m_clen += 64'(norm(msg_q[i].n) * 8);
        else            m_alen += 64'(norm(msg_q[i].n) * 8);
        if (msg_q[i].t)     m_seen_ct = 1'b1;
        else if (m_seen_ct) m_oerr = 1'b1;
        if (fin) phase = 2;
    endtask

    task automatic finish_msg(input int hold, input bit force_start);
        if (phase == 1) begin
            idle_inputs();
            fin_i = 1'b1;
            exp_a = m_y;
            chk_a = 1'b1;
            tick();
            phase = 2;
        end
        idle_inputs();
        blk_valid_i = 1'($urandom_range(0, 1));
        fin_i       = 1'($urandom_range(0, 1));
        start_i     = 1'($urandom_range(0, 1));
        exp_a       = m_y ^ {m_alen, m_clen};
        chk_a       = 1'b1;
        tick();
        m_tag = gf_mul(exp_a, m_h);
        phase = 3;
        repeat (hold) begin
            idle_inputs();
            start_i     = force_start ? 1'b1 : 1'($urandom_range(0, 1));
            blk_valid_i = 1'($urandom_range(0, 1));
            fin_i       = 1'($urandom_range(0, 1));
            chk_a       = 1'b0;
            tick();
        end
        idle_inputs();
        tag_ready_i = 1'b1;
        start_i     = force_start ? 1'b1 : 1'($urandom_range(0, 1));
        chk_a       = 1'b0;
        tick();
        phase = 0;
        idle_inputs();
    endtask

    task automatic run_msg(input logic [127:0] h, input bit fin_with_last, input int max_gap,
                           input int hold, input bit force_start);
        start_msg(h);
        for (int i = 0; i < msg_q.size(); i++)
            send_block(i, fin_with_last && (i == msg_q.size() - 1), max_gap);
        finish_msg(hold, force_start);
    endtask

    localparam logic [127:0] TC_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] TC_C   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] TC_TAG = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

    initial begin
        logic [127:0] garb, pexp;
        rst = 1'b1;
        model_zero();
        idle_inputs();
        #1;
        chk("rst_tag", tag_o, 128'd0);
        chk("rst_ready", 128'(blk_ready_o), 128'd0);
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_tag_valid", 128'(tag_valid_o), 128'd0);
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Empty message
        msg_q.delete();
        run_msg(TC_H, 1'b0, 0, 0, 1'b0);
        chk("empty_tag", tag_o, 128'd0);

        // GCM test case 2, fin on the block
        msg_q.delete();
        msg_q.push_back('{d: TC_C, t: 1'b1, n: 5'd16});
        run_msg(TC_H, 1'b1, 0, 1, 1'b0);
        chk("tc2_model", m_tag, TC_TAG);
        chk("tc2_tag", tag_o, TC_TAG);

        // Partial block with garbage beyond byte 3
        garb = {32'hdeadbeef, 96'h0123456789abcdef0f1e2d3c};
        msg_q.delete();
        msg_q.push_back('{d: garb, t: 1'b1, n: 5'd4});
        run_msg(TC_H, 1'b0, 1, 0, 1'b0);
        pexp = gf_mul(gf_mul({32'hdeadbeef, 96'd0}, TC_H) ^ {64'd0, 64'd32}, TC_H);
        chk("partial_ctlen", 128'(m_clen), 128'd32);
        chk("partial_tag", tag_o, pexp);

        // Tag backpressure for 10 cycles with start held high
        msg_q.delete();
        msg_q.push_back('{d: rnd128(), t: 1'b0, n: 5'd16});
        msg_q.push_back('{d: rnd128(), t: 1'b1, n: 5'd16});
        run_msg(rnd128(), 1'b0, 0, 10, 1'b1);

        // Reset after 2 of 3 blocks
        msg_q.delete();
        for (int i = 0; i < 3; i++) msg_q.push_back('{d: rnd128(), t: 1'(i), n: 5'd16});
        start_msg(rnd128());
        send_block(0, 1'b0, 0);
        send_block(1, 1'b0, 0);
        idle_inputs();
        chk_a = 1'b0;
        #2;
        rst = 1'b1;
        model_zero();
        #1;
        chk("mid_rst_tag", tag_o, 128'd0);
        chk("mid_rst_mul_a", mul_a_o, 128'd0);
        chk("mid_rst_mul_h", mul_h_o, 128'd0);
        chk("mid_rst_busy", 128'(busy_o), 128'd0);
        chk("mid_rst_ready", 128'(blk_ready_o), 128'd0);
        tick();
        tick();
        rst = 1'b0;
        run_msg(rnd128(), 1'b1, 0, 1, 1'b0);

        // AAD, CT, AAD ordering
        msg_q.delete();
        msg_q.push_back('{d: rnd128(), t: 1'b0, n: 5'd16});
        msg_q.push_back('{d: rnd128(), t: 1'b1, n: 5'd16});
        msg_q.push_back('{d: rnd128(), t: 1'b0, n: 5'd7});
        run_msg(rnd128(), 1'b1, 1, 2, 1'b0);
`ifdef GHASH_ORDER_CHK_EN
        chk("order_err_held", 128'(order_err_o), 128'd1);
`endif

        // Randomized messages
        for (int m = 0; m < 30; m++) begin
            msg_q.delete();
            for (int i = 0; i < int'($urandom_range(0, 5)); i++)
                msg_q.push_back('{d: rnd128(), t: 1'($urandom_range(0, 1)),
                                  n: 5'($urandom_range(0, 1) ? 16 : $urandom_range(0, 31))});
            run_msg(rnd128(), 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3), 1'b0);
        end

        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
